approx_mul_rr_sched: RTL and testbench
======================================

# approx_mul_rr_sched

Round-robin scheduler that shares one combinational unsigned 8x8 approximate multiplier among N_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives registered operands to the shared multiplier. It pipelines the 16-bit product and returns it, tagged with the requester index, through a credit-protected output FIFO with valid/ready backpressure. The block sits between the requesting datapath units and the approximate multiplier instance; it contains no arithmetic of its own.

## Interface
- N_REQ, 4, number of requesters (2..8); ID_W = max(1, clog2(N_REQ))
- PIPE, 1, product register stages between mul_z and the FIFO write (0..3)
- DEPTH, 4, output FIFO entries (power of two, >= PIPE+1)

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  operand pair valid, one bit per requester
- req_x  in  8*N_REQ  multiplicand; requester i on bits [8i+7:8i]
- req_y  in  8*N_REQ  multiplier operand, same packing
- req_ready  out  N_REQ  one-hot or zero; accept for requester i
- mul_x  out  8  registered operand to the shared multiplier
- mul_y  out  8  registered operand to the shared multiplier
- mul_z  in  16  combinational product of mul_x, mul_y
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer accepts head
- rsp_id  out  ID_W  requester index of head
- rsp_z  out  16  product of head
- busy  out  1  any operation in flight or queued

## Operation
- Accept: requester i transfers on an edge where req_valid[i] & req_ready[i]. At most one accept per cycle.
- Credit: occ = (operand stage valid) + (valid PIPE stages) + fifo_count. Issue is allowed only when occ < DEPTH, so the FIFO can never overflow and the pipe never stalls.
- Arbitration: round-robin. The search starts at last_grant+1 and wraps modulo N_REQ. The first requester found with req_valid high gets req_ready, provided issue is allowed.
  - If issue is not allowed, req_ready is all zero and last_grant holds.
  - last_grant updates to the granted index only on an accept.
  - req_ready may depend combinationally on req_valid. A requester must not make req_valid depend on req_ready.
- Issue stage: on accept, load mul_x/mul_y from the granted requester's operands, set op_valid, and record the id. With no accept, op_valid clears and mul_x/mul_y hold their previous values.
- Product path: mul_z is sampled on the edge after issue together with the id, then passes through PIPE registers (PIPE=0 means mul_z goes directly to the FIFO write).
- FIFO: write at pipe exit, pop on rsp_valid & rsp_ready. A simultaneous write and pop leaves the count unchanged. rsp_id and rsp_z come from registered storage; they are valid only while rsp_valid is high.
- busy = op_valid | any pipe valid | (fifo_count != 0).
- Results return in acceptance order. The product value is passed through unmodified; this block does not check or correct approximation error.

## Timing
- Reset (rst high at an edge): op_valid, pipe valids, fifo_count and pointers are cleared.
  - last_grant = N_REQ-1, so requester 0 has highest priority first.
  - mul_x = mul_y = 0, rsp_valid = 0, busy = 0; rsp_id/rsp_z read 0.
  - req_ready is forced to 0 during any cycle in which rst is high.
  - Reset mid-operation discards all in-flight and queued results; none are emitted afterwards.
- Latency: an accept at edge t gives rsp_valid high from edge t+1+PIPE when the FIFO is empty. Throughput is one result per cycle while rsp_ready is held high.
- Full: occ == DEPTH gives req_ready = 0. A pop in cycle c frees a credit for an accept at the same edge (occ is computed including the pop).
- Empty: rsp_valid = 0. A write into an empty FIFO is visible on the following cycle (no bypass).
- rsp_ready low: the head is held stable, and rsp_id/rsp_z do not change until popped.

## Test plan
- Single request: requester 2, x=200, y=100, PIPE=1, rsp_ready=1.
  -> mul_x=200, mul_y=100 after edge t; rsp_valid rises at edge t+2 with rsp_id=2 and rsp_z equal to the bench's approximate-multiplier model output for (200,100); busy drops one cycle after the pop.
- All four requesters valid continuously with distinct operands.
  -> grants follow 0,1,2,3,0,... one per cycle; responses return in that order with matching ids.
- rsp_ready=0, all requesters valid, DEPTH=4.
  -> exactly 4 accepts, then req_ready=0; raising rsp_ready for one cycle allows exactly one further accept at that edge.
- Operands x=255, y=255 and x=0, y=37.
  -> rsp_z equals the model value for each pair (0 for the second), with no truncation of the 16-bit path.
- rst asserted for one cycle with 3 results queued and 1 in flight.
  -> no rsp_valid afterwards; the next grant goes to requester 0; all outputs are at their reset values.
- Only requester 3 valid after a grant to requester 1.
  -> requester 3 is granted immediately (pointer wrap-around, no idle cycles).

Source files
------------

// File: rtl/approx_mul_rr_sched_if.sv
// Handshake and datapath bundle between requesters, the round-robin scheduler,
// the shared approximate multiplier and the response consumer.
interface approx_mul_rr_sched_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_x;
  logic [8*N_REQ-1:0] req_y;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         mul_x;
  logic [7:0]         mul_y;
  logic [15:0]        mul_z;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [15:0]        rsp_z;
  logic               busy;

  modport master (
    output req_valid, req_x, req_y, mul_z, rsp_ready,
    input  req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_z, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, mul_z, rsp_ready,
    output req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_z, busy
  );
endinterface

// File: rtl/approx_mul_rr_sched.sv
// Round-robin scheduler sharing one combinational 8x8 approximate multiplier,
// with a product pipeline and a credit-protected, in-order response FIFO.
module approx_mul_rr_sched #(
  parameter int N_REQ = 4,
  parameter int PIPE  = 1,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  approx_mul_rr_sched_if.slave bus
);
  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = AW + 1;

  logic [ID_W-1:0] last_grant_r;
  logic            op_valid_r;
  logic [ID_W-1:0] op_id_r;
  logic [7:0]      mul_x_r;
  logic [7:0]      mul_y_r;

  logic [ID_W-1:0] fifo_id_r [DEPTH];
  logic [15:0]     fifo_z_r  [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  logic            rsp_valid_s;
  logic            pop_s;
  logic [7:0]      occ_s;
  logic            allow_s;
  logic            found_s;
  logic [ID_W-1:0] gnt_id_s;
  logic [ID_W-1:0] idx_s;
  logic [N_REQ-1:0] ready_s;
  logic            accept_s;
  logic            wr_v_s;
  logic [ID_W-1:0] wr_id_s;
  logic [15:0]     wr_z_s;
  logic [2:0]      pipe_cnt_s;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + {{(AW-1){1'b0}}, 1'b1};
  endfunction

  assign rsp_valid_s = (count_r != {CW{1'b0}});
  assign pop_s       = rsp_valid_s & bus.rsp_ready;

  // Credit check: everything accepted but not yet popped, counting this cycle's pop as freed
  always_comb begin
    occ_s   = 8'(op_valid_r) + 8'(pipe_cnt_s) + 8'(count_r) - 8'(pop_s);
    allow_s = !rst && (occ_s < 8'(DEPTH));
  end

  // Round-robin search starting one past the last accepted requester
  always_comb begin
    found_s  = 1'b0;
    gnt_id_s = last_grant_r;
    idx_s    = {ID_W{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      idx_s = ID_W'((int'(last_grant_r) + k) % N_REQ);
      if (!found_s && bus.req_valid[idx_s]) begin
        found_s  = 1'b1;
        gnt_id_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Grant vector; zero when no credit, no request, or in reset
  always_comb begin
    ready_s = {N_REQ{1'b0}};
    if (found_s && allow_s) begin
      ready_s[gnt_id_s] = 1'b1;
    end else begin
      ready_s = {N_REQ{1'b0}};
    end
  end

  assign accept_s = found_s & allow_s;

  // Issue stage: operand registers, tag and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid_r   <= 1'b0;
      op_id_r      <= {ID_W{1'b0}};
      mul_x_r      <= 8'd0;
      mul_y_r      <= 8'd0;
      last_grant_r <= ID_W'(N_REQ - 1);
    end else begin
      op_valid_r <= accept_s;
      if (accept_s) begin
        op_id_r      <= gnt_id_s;
        mul_x_r      <= bus.req_x[{gnt_id_s, 3'b000} +: 8];
        mul_y_r      <= bus.req_y[{gnt_id_s, 3'b000} +: 8];
        last_grant_r <= gnt_id_s;
      end
    end
  end

  generate
    if (PIPE == 0) begin : g_direct
      // Product written straight into the FIFO on the edge after issue
      always_comb begin
        wr_v_s     = op_valid_r;
        wr_id_s    = op_id_r;
        wr_z_s     = bus.mul_z;
        pipe_cnt_s = 3'd0;
      end
    end else begin : g_pipe
      logic [PIPE-1:0] pv_r;
      logic [ID_W-1:0] pid_r [PIPE];
      logic [15:0]     pz_r  [PIPE];

      // Product shift pipeline; stage 0 samples mul_z with its tag
      always_ff @(posedge clk) begin
        if (rst) begin
          pv_r <= {PIPE{1'b0}};
          for (int i = 0; i < PIPE; i++) begin
            pid_r[i] <= {ID_W{1'b0}};
            pz_r[i]  <= 16'd0;
          end
        end else begin
          pv_r[0]  <= op_valid_r;
          pid_r[0] <= op_id_r;
          pz_r[0]  <= bus.mul_z;
          for (int i = 1; i < PIPE; i++) begin
            pv_r[i]  <= pv_r[i-1];
            pid_r[i] <= pid_r[i-1];
            pz_r[i]  <= pz_r[i-1];
          end
        end
      end

      // Pipe exit feeds the FIFO write port
      always_comb begin
        wr_v_s     = pv_r[PIPE-1];
        wr_id_s    = pid_r[PIPE-1];
        wr_z_s     = pz_r[PIPE-1];
        pipe_cnt_s = 3'($countones(pv_r));
      end
    end
  endgenerate

  // Response FIFO; storage is cleared so the head reads zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_id_r[i] <= {ID_W{1'b0}};
        fifo_z_r[i]  <= 16'd0;
      end
    end else begin
      if (wr_v_s) begin
        fifo_id_r[wr_ptr_r] <= wr_id_s;
        fifo_z_r[wr_ptr_r]  <= wr_z_s;
        wr_ptr_r            <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      count_r <= count_r + CW'(wr_v_s) - CW'(pop_s);
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.mul_x     = mul_x_r;
  assign bus.mul_y     = mul_y_r;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_id    = fifo_id_r[rd_ptr_r];
  assign bus.rsp_z     = fifo_z_r[rd_ptr_r];
  assign bus.busy      = op_valid_r | (pipe_cnt_s != 3'd0) | rsp_valid_s;
endmodule

// File: tb/tb_approx_mul_rr_sched.sv
// Self-checking bench: directed vector table, corner sequences and random traffic
// checked against a queue-based model of grants, credits and in-order responses.
module tb_approx_mul_rr_sched;
  localparam int N_REQ = 4;
  localparam int PIPE  = 1;
  localparam int DEPTH = 4;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Approximate multiplier stand-in: exact product with the low nibble dropped
  function automatic logic [15:0] approx(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    return {p[15:4], 4'b0000};
  endfunction

  approx_mul_rr_sched_if #(.N_REQ(N_REQ)) bus();
  approx_mul_rr_sched #(.N_REQ(N_REQ), .PIPE(PIPE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  assign bus.mul_z = approx(bus.mul_x, bus.mul_y);

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [ID_W-1:0] id; logic [15:0] z; } exp_t;
  exp_t sbq[$];
  int   m_lg;

  typedef struct { int id; logic [7:0] x; logic [7:0] y; logic [15:0] z; } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y);
    bus.req_x[8*i +: 8] = x;
    bus.req_y[8*i +: 8] = y;
  endtask

  // Model: every accepted-but-unpopped item is one used credit; grants rotate
  task automatic monitor();
    int pend;
    int g;
    int idx;
    logic [N_REQ-1:0] er;
    if (rst) begin
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      sbq.delete();
      m_lg = N_REQ - 1;
    end else begin
      chk("busy", 32'(bus.busy), 32'(sbq.size() != 0));
      if (bus.rsp_valid) begin
        if (sbq.size() == 0) chk("rsp_valid_empty", 32'(bus.rsp_valid), 32'd0);
        else begin
          chk("rsp_id", 32'(bus.rsp_id), 32'(sbq[0].id));
          chk("rsp_z", 32'(bus.rsp_z), 32'(sbq[0].z));
        end
      end
      pend = sbq.size() - ((bus.rsp_valid && bus.rsp_ready) ? 1 : 0);
      g = -1;
      er = '0;
      if (pend < DEPTH) begin
        for (int k = 1; k <= N_REQ; k++) begin
          idx = (m_lg + k) % N_REQ;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      if (bus.rsp_valid && bus.rsp_ready && sbq.size() > 0) void'(sbq.pop_front());
      if (g >= 0) begin
        sbq.push_back({ID_W'(g), approx(bus.req_x[8*g +: 8], bus.req_y[8*g +: 8])});
        m_lg = g;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mul_x"}, 32'(bus.mul_x), 32'd0);
    chk({tag, "_mul_y"}, 32'(bus.mul_y), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
    chk({tag, "_rsp_z"}, 32'(bus.rsp_z), 32'd0);
  endtask

  initial begin
    int lat;
    int acc;
    int seen;
    int last;

    tbl[0] = '{2, 8'd200, 8'd100, 16'h4E20};
    tbl[1] = '{3, 8'd255, 8'd255, 16'hFE00};
    tbl[2] = '{0, 8'd0,   8'd37,  16'h0000};
    tbl[3] = '{1, 8'd16,  8'd16,  16'h0100};
    tbl[4] = '{0, 8'd1,   8'd15,  16'h0000};
    tbl[5] = '{1, 8'd255, 8'd1,   16'h00F0};

    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.rsp_ready = 1'b0;
    m_lg = N_REQ - 1;
    tick();
    tick();
    #1 chk("rst_ready_hold", 32'(bus.req_ready), 32'd0);
    chk_reset_vals("reset");
    rst = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();

    // Directed single requests: operand issue, latency, id/product, busy drop
    for (int v = 0; v < 6; v++) begin
      set_req(tbl[v].id, tbl[v].x, tbl[v].y);
      bus.req_valid = '0;
      bus.req_valid[tbl[v].id] = 1'b1;
      tick();
      bus.req_valid = '0;
      chk("vec_mul_x", 32'(bus.mul_x), 32'(tbl[v].x));
      chk("vec_mul_y", 32'(bus.mul_y), 32'(tbl[v].y));
      lat = 0;
      while (!bus.rsp_valid && lat < 10) begin
        tick();
        lat++;
      end
      chk("vec_latency", 32'(lat), 32'(PIPE + 1));
      chk("vec_rsp_id", 32'(bus.rsp_id), 32'(tbl[v].id));
      chk("vec_rsp_z", 32'(bus.rsp_z), 32'(tbl[v].z));
      tick();
      chk("vec_busy_after_pop", 32'(bus.busy), 32'd0);
      chk("vec_rsp_valid_after_pop", 32'(bus.rsp_valid), 32'd0);
    end

    // All requesters valid: strict rotation, one grant per cycle
    last = tbl[5].id;
    for (int i = 0; i < N_REQ; i++) set_req(i, 8'($urandom), 8'($urandom));
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_grant", 32'(bus.req_ready), 32'(1) << ((last + 1 + k) % N_REQ));
      tick();
    end
    bus.req_valid = '0;
    repeat (6) tick();

    // Backpressure: DEPTH accepts, then a single pop buys exactly one more
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      #1 if (|(bus.req_ready & bus.req_valid)) acc++;
      tick();
    end
    chk("full_accepts", 32'(acc), 32'(DEPTH));
    #1 chk("full_ready", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    #1 chk("credit_onehot", 32'($countones(bus.req_ready)), 32'd1);
    tick();
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      #1 if (|(bus.req_ready & bus.req_valid)) acc++;
      tick();
    end
    chk("after_credit_accepts", 32'(acc), 32'd0);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (10) tick();

    // Reset with three results queued and one in flight
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    repeat (4) tick();
    bus.req_valid = '0;
    tick();
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    chk("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b1;
    bus.req_valid = '1;
    #1 chk("in_rst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    chk_reset_vals("midrst");
    seen = 0;
    repeat (5) begin
      #1 if (bus.rsp_valid) seen++;
      tick();
    end
    chk("no_rsp_after_rst", 32'(seen), 32'd0);
    bus.req_valid = '1;
    #1 chk("post_rst_grant", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = '0;
    repeat (6) tick();

    // Pointer wrap: grant 1, then lone requester 3 is served at once
    bus.req_valid = 4'b0010;
    #1 chk("wrap_grant1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b1000;
    #1 chk("wrap_grant3", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = '0;
    repeat (6) tick();

    // Random traffic against the model
    repeat (400) begin
      bus.req_valid = 4'($urandom);
      for (int i = 0; i < N_REQ; i++) set_req(i, 8'($urandom), 8'($urandom));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (20) tick();
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    #1 chk("drain_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
